// File: rtl/flag_pipe.sv
// flag_pipe: pipelined zero/negative/carry/overflow evaluation with a registered flags register.
// Ports:
//   clk, reset      single clock; synchronous active-high reset
//   in_valid        result/carry_in/ovf_in/set_flags describe an op this cycle
//   result          ALU result (WIDTH bits) reduced by a RADIX-ary OR tree
//   carry_in/ovf_in ALU carry-out and signed overflow of the op
//   set_flags       op updates the architectural flags register
//   stall, flush    hold every stage / kill every in-flight op (flush wins)
//   out_valid       per-op outputs below describe the op leaving the pipe
//   zero, negative, carry, overflow  per-op flags, forced to 0 while out_valid=0
//   flags           architectural register {negative, zero, overflow, carry}
module flag_pipe #(
    parameter int WIDTH = 64,
    parameter int RADIX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] result,
    input  logic             carry_in,
    input  logic             ovf_in,
    input  logic             set_flags,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic [3:0]       flags
);

    // Number of bits left after k levels of RADIX-wide reduction.
    function automatic int stage_w(int k);
        int w = WIDTH;
        for (int i = 0; i < k; i++) w = (w + RADIX - 1) / RADIX;
        return w;
    endfunction

    function automatic int calc_lat();
        int l = 1;
        while (stage_w(l) > 1) l++;
        return l;
    endfunction

    localparam int LAT = calc_lat();

    logic [LAT-1:0] vld, neg_q, cy_q, ov_q, sf_q;
    logic           fin;
    logic           load;

    // Each stage ORs RADIX-bit groups of the previous stage; the last group
    // is zero-extended so a partial group never picks up stray bits.
    for (genvar s = 0; s < LAT; s++) begin : g_stage
        localparam int IW = stage_w(s);
        localparam int OW = stage_w(s + 1);
        localparam int PW = OW * RADIX;
        logic [IW-1:0] d;
        logic [PW-1:0] pad;
        logic [OW-1:0] ors;
        logic [OW-1:0] q;
        if (s == 0) begin : g_first
            assign d = result;
        end else begin : g_next
            assign d = g_stage[s-1].q;
        end
        assign pad = PW'(d);
        for (genvar j = 0; j < OW; j++) begin : g_or
            assign ors[j] = |pad[j*RADIX +: RADIX];
        end
        always_ff @(posedge clk) begin
            if (reset) q <= '0;
            else if (!stall) q <= ors;
        end
    end

    assign fin       = g_stage[LAT-1].q[0];
    assign out_valid = vld[LAT-1];
    assign zero      = out_valid & ~fin;
    assign negative  = out_valid & neg_q[LAT-1];
    assign carry     = out_valid & cy_q[LAT-1];
    assign overflow  = out_valid & ov_q[LAT-1];
    assign load      = out_valid & sf_q[LAT-1] & ~stall & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld   <= '0;
            neg_q <= '0;
            cy_q  <= '0;
            ov_q  <= '0;
            sf_q  <= '0;
            flags <= '0;
        end else begin
            if (!stall) begin
                neg_q <= LAT'({neg_q, result[WIDTH-1]});
                cy_q  <= LAT'({cy_q, carry_in});
                ov_q  <= LAT'({ov_q, ovf_in});
                sf_q  <= LAT'({sf_q, set_flags});
            end
            if (flush) vld <= '0;
            else if (!stall) vld <= LAT'({vld, in_valid});
            if (load) flags <= {negative, zero, overflow, carry};
        end
    end

endmodule

// File: tb/tb_flag_pipe.sv
// tb_flag_pipe: randomized and directed checks of flag_pipe against a behavioural model.
module tb_flag_pipe;

    logic         clk = 0;
    logic         reset, in_valid, carry_in, ovf_in, set_flags, stall, flush;
    logic [127:0] res;
    logic         ov [3], zz [3], nn [3], cc [3], oo [3];
    logic [3:0]   fl [3];
    int           n_cmp = 0, n_bad = 0;
    bit           chk_en = 0;

    always #5 clk = ~clk;

    flag_pipe #(.WIDTH(64), .RADIX(4)) u_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .result(res[63:0]),
        .carry_in(carry_in), .ovf_in(ovf_in), .set_flags(set_flags),
        .stall(stall), .flush(flush), .out_valid(ov[0]), .zero(zz[0]),
        .negative(nn[0]), .carry(cc[0]), .overflow(oo[0]), .flags(fl[0]));

    flag_pipe #(.WIDTH(5), .RADIX(2)) u_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .result(res[4:0]),
        .carry_in(carry_in), .ovf_in(ovf_in), .set_flags(set_flags),
        .stall(stall), .flush(flush), .out_valid(ov[1]), .zero(zz[1]),
        .negative(nn[1]), .carry(cc[1]), .overflow(oo[1]), .flags(fl[1]));

    flag_pipe #(.WIDTH(128), .RADIX(8)) u_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .result(res),
        .carry_in(carry_in), .ovf_in(ovf_in), .set_flags(set_flags),
        .stall(stall), .flush(flush), .out_valid(ov[2]), .zero(zz[2]),
        .negative(nn[2]), .carry(cc[2]), .overflow(oo[2]), .flags(fl[2]));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: all three configurations have three stages. An op is reduced to
    // its flag values on entry (plain ==0 and sign bit per width) and then
    // just travels through three slots.
    typedef struct packed {
        bit       v;
        bit [2:0] z;
        bit [2:0] n;
        bit       c, o, sf;
    } op_t;
    op_t      pipe [3];
    bit [3:0] mfl [3];

    always @(posedge clk) begin
        op_t nw;
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                pipe[i] = '0;
                mfl[i]  = '0;
            end
        end else begin
            if (!stall && !flush && pipe[2].v && pipe[2].sf)
                for (int i = 0; i < 3; i++)
                    mfl[i] = {pipe[2].n[i], pipe[2].z[i], pipe[2].o, pipe[2].c};
            if (!stall) begin
                nw.v  = in_valid;
                nw.z  = {res == 0, res[4:0] == 0, res[63:0] == 0};
                nw.n  = {res[127], res[4], res[63]};
                nw.c  = carry_in;
                nw.o  = ovf_in;
                nw.sf = set_flags;
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = nw;
            end
            if (flush) for (int i = 0; i < 3; i++) pipe[i].v = 0;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("m_valid%0d", i), ov[i], pipe[2].v);
                check($sformatf("m_zero%0d", i), zz[i], pipe[2].v & pipe[2].z[i]);
                check($sformatf("m_neg%0d", i), nn[i], pipe[2].v & pipe[2].n[i]);
                check($sformatf("m_carry%0d", i), cc[i], pipe[2].v & pipe[2].c);
                check($sformatf("m_ovf%0d", i), oo[i], pipe[2].v & pipe[2].o);
                check($sformatf("m_flags%0d", i), fl[i], mfl[i]);
            end
        end
    end

    task automatic drive(input logic v, input logic [127:0] r, input logic c,
                         input logic o, input logic sf);
        @(negedge clk);
        reset = 0; stall = 0; flush = 0;
        in_valid = v; res = r; carry_in = c; ovf_in = o; set_flags = sf;
    endtask

    task automatic post(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd_res();
        logic [127:0] r;
        case ($urandom_range(0, 4))
            0:       r = '0;
            1:       r = 128'(1) << $urandom_range(0, 127);
            2:       r = 128'(1) << $urandom_range(0, 6);
            default: r = {$urandom, $urandom, $urandom, $urandom};
        endcase
        return r;
    endfunction

    localparam logic [127:0] MSB64 = 128'h8000000000000000;

    initial begin
        logic [127:0] sv [4];
        bit           ez [4];
        sv = '{128'h0, 128'h1, 128'h0, 128'hAAAAAAAAAAAAAAAA};
        ez = '{1, 0, 1, 0};
        reset = 1; in_valid = 0; res = '0; carry_in = 0; ovf_in = 0;
        set_flags = 0; stall = 0; flush = 0;
        post(2);
        chk_en = 1;
        check("rst_valid", ov[0], 0);
        check("rst_flags", fl[0], 4'b0000);

        // single zero op with set_flags
        drive(1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        post(2);
        check("a_valid", ov[0], 1);
        check("a_zero", zz[0], 1);
        check("a_neg", nn[0], 0);
        post(1);
        check("a_flags", fl[0], 4'b0100);
        check("a_valid_after", ov[0], 0);

        // negative with carry and overflow
        drive(1, MSB64, 1, 1, 1);
        drive(0, 0, 0, 0, 0);
        post(2);
        check("b_zero", zz[0], 0);
        check("b_neg", nn[0], 1);
        check("b_carry", cc[0], 1);
        check("b_ovf", oo[0], 1);
        post(1);
        check("b_flags", fl[0], 4'b1011);

        // back-to-back stream without set_flags
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k >= 3) check($sformatf("c_zero%0d", k - 3), zz[0], ez[k-3]);
            in_valid = (k < 4);
            if (k < 4) res = sv[k];
            set_flags = 0; carry_in = 0; ovf_in = 0;
        end
        check("c_flags", fl[0], 4'b1011);

        // three-cycle stall while the op sits in stage 2
        drive(1, 5, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        stall = 1;
        repeat (3) @(negedge clk);
        check("d_valid_held", ov[0], 0);
        check("d_flags_held", fl[0], 4'b1011);
        stall = 0;
        post(1);
        check("d_valid", ov[0], 1);
        check("d_zero", zz[0], 0);
        post(1);
        check("d_flags", fl[0], 4'b0000);

        // flush two in-flight ops, with a new op offered on the flush edge
        drive(1, MSB64, 1, 1, 1);
        drive(1, 0, 0, 1, 1);
        @(negedge clk);
        flush = 1; in_valid = 1; res = MSB64; set_flags = 1;
        @(negedge clk);
        check("e_valid0", ov[0], 0);
        flush = 0; in_valid = 0;
        for (int k = 1; k <= 4; k++) begin
            post(1);
            check($sformatf("e_valid%0d", k), ov[0], 0);
        end
        check("e_flags", fl[0], 4'b0000);

        // reset mid-stream, then first op after reset
        drive(1, MSB64, 1, 1, 1);
        drive(1, MSB64, 1, 1, 1);
        drive(1, MSB64, 1, 1, 1);
        @(negedge clk);
        reset = 1;
        post(1);
        check("f_valid", ov[0], 0);
        check("f_zero", zz[0], 0);
        check("f_neg", nn[0], 0);
        check("f_carry", cc[0], 0);
        check("f_ovf", oo[0], 0);
        check("f_flags", fl[0], 4'b0000);
        drive(1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        post(2);
        check("f_first_valid", ov[0], 1);
        check("f_first_zero", zz[0], 1);

        // narrow configuration: WIDTH=5, RADIX=2
        drive(1, 128'h10, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        post(1);
        check("g_zero_b", zz[1], 0);
        check("g_neg_b", nn[1], 1);
        check("g_zero_c", zz[2], 0);
        post(1);
        check("g_zero_b2", zz[1], 1);
        check("g_neg_b2", nn[1], 0);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            reset     = ($urandom_range(0, 99) == 0);
            stall     = ($urandom_range(0, 99) < 20);
            flush     = ($urandom_range(0, 99) < 5);
            in_valid  = ($urandom_range(0, 3) != 0);
            res       = rnd_res();
            carry_in  = 1'($urandom);
            ovf_in    = 1'($urandom);
            set_flags = 1'($urandom);
        end
        drive(0, 0, 0, 0, 0);
        post(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/flag_pipe.md
FLAG_PIPE -- requirements
Module: flag_pipe

Interface
REQ-001 Parameter WIDTH, default 64, bit width of the checked result; legal range 2..128.
REQ-002 Parameter RADIX, default 4, OR-tree fan-in per level; legal values 2, 4, 8.
REQ-003 Derived constant LAT = ceil(log_RADIX(WIDTH)), minimum 1; LAT = 3 at defaults.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  reset is synchronous and active-high.
REQ-006 in_valid  input  1  result and side flags valid this cycle.
REQ-007 result  input  WIDTH  ALU result to evaluate.
REQ-008 carry_in  input  1  ALU carry-out for this result.
REQ-009 ovf_in  input  1  ALU signed overflow for this result.
REQ-010 set_flags  input  1  this op updates the architectural flags register.
REQ-011 stall  input  1  hold all pipeline stages.
REQ-012 flush  input  1  kill all in-flight ops.
REQ-013 out_valid  output  1  flag outputs below are valid.
REQ-014 zero, negative, carry, overflow  output  1 each  per-op flags of the op leaving the pipe.
REQ-015 flags  output  4  architectural register {negative, zero, overflow, carry}, MSB first.

Function
REQ-016 Stage 1 SHALL register RADIX-wide ORs of result; missing upper bits of a partial last group are zero.
REQ-017 Each later stage SHALL register RADIX-wide ORs of the previous stage, with zero padding; the final stage holds one bit.
REQ-018 zero SHALL equal the inverse of the final-stage OR bit.
REQ-019 negative = result[WIDTH-1], carry = carry_in, overflow = ovf_in, and set_flags SHALL be delayed in lockstep with the tree.
REQ-020 Latency: op accepted at edge N with stall low SHALL appear with out_valid=1 after edge N+LAT-1.
REQ-021 Throughput: one op per cycle; no bubbles inserted when stall is low.
REQ-022 Each stage SHALL carry a valid bit; out_valid = valid bit of the last stage.
REQ-023 stall=1: all stage registers, valid bits and flags SHALL hold; in_valid is ignored; outputs hold their values.
REQ-024 flags SHALL load {negative, zero, overflow, carry} on the edge where out_valid=1, the delayed set_flags=1 and stall=0; otherwise flags hold.
REQ-025 The flags load SHALL happen one cycle after out_valid, so flags reflects an op from the cycle after it exits.
REQ-026 flush=1 SHALL clear every valid bit on that edge, including the stage accepting in_valid; no flags load occurs on that edge.
REQ-027 flush SHALL override stall.
REQ-028 Data registers of invalid stages are don't-care, but the zero/negative/carry/overflow outputs SHALL read 0 while out_valid=0.
REQ-029 Back-to-back ops with alternating zero/non-zero results SHALL produce independent, correctly ordered flags.

Reset
REQ-030 reset SHALL take precedence over flush, stall and in_valid.
REQ-031 On reset: all valid bits 0, out_valid 0, zero/negative/carry/overflow 0, flags 4'b0000.
REQ-032 Reset mid-operation SHALL discard all in-flight ops; the first op after reset deasserts obeys REQ-020.

Verification
REQ-033 Defaults: result=0, in_valid=1, set_flags=1 at edge 0 -> after edge 2, out_valid=1, zero=1, negative=0; after edge 3, flags=4'b0100.
REQ-034 result=64'h8000000000000000, carry_in=1, ovf_in=1, set_flags=1 -> zero=0, negative=1, carry=1, overflow=1; flags=4'b1011 one cycle later.
REQ-035 Stream results 0, 1, 0, 64'hAAAAAAAAAAAAAAAA on consecutive cycles with set_flags=0 -> zero sequence 1, 0, 1, 0 on consecutive cycles starting at LAT; flags unchanged.
REQ-036 Issue an op, raise stall for 3 cycles while it is mid-pipe -> out_valid is delayed by exactly 3 cycles and flag values are unchanged.
REQ-037 Issue 2 ops, assert flush while they are in flight -> out_valid never rises for them and flags keep their prior value; assert reset mid-stream -> all outputs are 0 on the next cycle.
REQ-038 WIDTH=5, RADIX=2 (LAT=3) -> result=5'b10000 gives zero=0, negative=1; result=0 gives zero=1.
